// File: rtl/preempt_timer.sv
// Pre-emption countdown timer: loaded from the internal bus, counts down while
// unprivileged, raises timeout until acknowledged, then auto-reloads and resumes.
module preempt_timer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PRESCALE   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  timer_in,
  input  logic [DATA_WIDTH-1:0] bus_in,
  input  logic                  privileged,
  input  logic                  timeout_ack,
  output logic                  timeout,
  output logic                  armed,
  output logic [DATA_WIDTH-1:0] count,
  output logic [1:0]            timer_state
);

  localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [DATA_WIDTH-1:0] COUNT_ONE = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_EXPIRED  = 2'd2,
    ST_ILLEGAL  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] reload_q, reload_d;
  logic [PW-1:0]         pre_q, pre_d;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_DISARMED;
      count_q  <= '0;
      reload_q <= '0;
      pre_q    <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      pre_q    <= pre_d;
    end
  end

  // Next-state: load beats acknowledge beats tick
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    pre_d    = pre_q;
    if (timer_in) begin
      reload_d = bus_in;
      count_d  = bus_in;
      pre_d    = '0;
      state_d  = (bus_in == '0) ? ST_DISARMED : ST_RUNNING;
    end else begin
      case (state_q)
        ST_DISARMED: ;
        ST_RUNNING: begin
          // Privileged cycles freeze the prescaler so partial periods survive
          if (!privileged) begin
            if (pre_q == PRE_LAST) begin
              pre_d = '0;
              if (count_q <= COUNT_ONE) begin
                count_d = '0;
                state_d = ST_EXPIRED;
              end else begin
                count_d = count_q - COUNT_ONE;
              end
            end else begin
              pre_d = pre_q + PW'(1);
            end
          end
        end
        ST_EXPIRED: begin
          count_d = '0;
          pre_d   = '0;
          if (timeout_ack) begin
            count_d = reload_q;
            state_d = ST_RUNNING;
          end
        end
        default: begin
          state_d = ST_DISARMED;
          count_d = '0;
          pre_d   = '0;
        end
      endcase
    end
  end

  assign timeout     = (state_q == ST_EXPIRED);
  assign armed       = (state_q == ST_RUNNING);
  assign count       = count_q;
  assign timer_state = state_q;

endmodule

// File: tb/tb_preempt_timer.sv
// Bench for preempt_timer: PRESCALE=1 and PRESCALE=4 instances share stimulus
// and are checked every cycle against an abstract reference model.
module tb_preempt_timer;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          timer_in;
  logic [DW-1:0] bus_in;
  logic          privileged;
  logic          timeout_ack;

  logic          timeout1, armed1, timeout4, armed4;
  logic [DW-1:0] count1, count4;
  logic [1:0]    state1, state4;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model, index 0 = PRESCALE 1, index 1 = PRESCALE 4
  int presc   [2];
  int m_mode  [2];   // 0 idle, 1 counting, 2 expired
  int m_count [2];
  int m_reload[2];
  int m_elap  [2];   // enabled cycles since last decrement

  always #5 clk = ~clk;

  preempt_timer #(.DATA_WIDTH(DW), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
    .privileged(privileged), .timeout_ack(timeout_ack),
    .timeout(timeout1), .armed(armed1), .count(count1), .timer_state(state1)
  );

  preempt_timer #(.DATA_WIDTH(DW), .PRESCALE(4)) dut4 (
    .clk(clk), .reset(reset), .timer_in(timer_in), .bus_in(bus_in),
    .privileged(privileged), .timeout_ack(timeout_ack),
    .timeout(timeout4), .armed(armed4), .count(count4), .timer_state(state4)
  );

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_mode[i] = 0; m_count[i] = 0; m_reload[i] = 0; m_elap[i] = 0;
      end else if (timer_in) begin
        m_reload[i] = int'(bus_in);
        m_count[i]  = int'(bus_in);
        m_elap[i]   = 0;
        m_mode[i]   = (bus_in == 0) ? 0 : 1;
      end else if (m_mode[i] == 2 && timeout_ack) begin
        m_count[i] = m_reload[i];
        m_elap[i]  = 0;
        m_mode[i]  = 1;
      end else if (m_mode[i] == 1 && !privileged) begin
        m_elap[i]++;
        if (m_elap[i] == presc[i]) begin
          m_elap[i] = 0;
          m_count[i]--;
          if (m_count[i] == 0) m_mode[i] = 2;
        end
      end
    end
  endtask

  task automatic compare_all();
    check("p1.timeout", int'(timeout1), int'(m_mode[0] == 2));
    check("p1.armed",   int'(armed1),   int'(m_mode[0] == 1));
    check("p1.count",   int'(count1),   m_count[0]);
    check("p1.state",   int'(state1),   m_mode[0]);
    check("p4.timeout", int'(timeout4), int'(m_mode[1] == 2));
    check("p4.armed",   int'(armed4),   int'(m_mode[1] == 1));
    check("p4.count",   int'(count4),   m_count[1]);
    check("p4.state",   int'(state4),   m_mode[1]);
  endtask

  // One clock: apply the edge to the model, then sample the DUTs 1ns later
  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle();
    timer_in = 1'b0; timeout_ack = 1'b0; bus_in = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1; idle(); privileged = 1'b0;
    repeat (3) cycle();
    reset = 1'b0;
  endtask

  task automatic load(input int value);
    timer_in = 1'b1; bus_in = DW'(value);
    cycle();
    idle();
  endtask

  initial begin
    presc[0] = 1; presc[1] = 4;
    for (int i = 0; i < 2; i++) begin
      m_mode[i] = 0; m_count[i] = 0; m_reload[i] = 0; m_elap[i] = 0;
    end

    // 1: reset
    do_reset();
    check("rst.timeout", int'(timeout1), 0);
    check("rst.armed",   int'(armed1),   0);
    check("rst.count",   int'(count1),   0);
    check("rst.state",   int'(state1),   0);

    // 2: load 5, expiry 5 cycles after load edge, held while idle
    load(5);
    check("t2.count_load", int'(count1), 5);
    for (int k = 1; k <= 5; k++) begin
      check("t2.timeout_pre", int'(timeout1), 0);
      cycle();
      check("t2.count", int'(count1), 5 - k);
    end
    check("t2.timeout", int'(timeout1), 1);
    repeat (10) cycle();
    check("t2.timeout_held", int'(timeout1), 1);

    // 3: acknowledge reloads and re-expires
    timeout_ack = 1'b1;
    cycle();
    idle();
    check("t3.timeout", int'(timeout1), 0);
    check("t3.count",   int'(count1),   5);
    check("t3.armed",   int'(armed1),   1);
    repeat (4) cycle();
    check("t3.not_yet", int'(timeout1), 0);
    cycle();
    check("t3.expired", int'(timeout1), 1);

    // 4: privileged freeze delays expiry by exactly 4 cycles
    do_reset();
    load(3);
    cycle();
    privileged = 1'b1;
    repeat (4) cycle();
    check("t4.frozen", int'(count1), 2);
    privileged = 1'b0;
    cycle();
    check("t4.not_yet", int'(timeout1), 0);
    cycle();
    check("t4.expired", int'(timeout1), 1);

    // 5: load 0 while running disarms; acks ignored
    load(7);
    cycle();
    load(0);
    for (int k = 0; k < 20; k++) begin
      timeout_ack = k[0];
      cycle();
    end
    idle();
    check("t5.timeout", int'(timeout1), 0);
    check("t5.count",   int'(count1),   0);
    check("t5.state",   int'(state1),   0);

    // 6: load wins over ack in EXPIRED; PRESCALE=4 decrements every 4th cycle
    load(2);
    repeat (10) cycle();
    check("t6.p4_expired", int'(timeout4), 1);
    timer_in = 1'b1; timeout_ack = 1'b1; bus_in = DW'(9);
    cycle();
    idle();
    check("t6.count",  int'(count4), 9);
    check("t6.armed",  int'(armed4), 1);
    repeat (3) cycle();
    check("t6.hold",   int'(count4), 9);
    cycle();
    check("t6.dec",    int'(count4), 8);

    // Randomized traffic against the model
    for (int k = 0; k < 3000; k++) begin
      reset       = ($urandom_range(0, 199) == 0);
      timer_in    = ($urandom_range(0, 15) == 0);
      bus_in      = ($urandom_range(0, 7) == 0) ? '0 : DW'($urandom_range(1, 12));
      privileged  = ($urandom_range(0, 3) == 0);
      timeout_ack = ($urandom_range(0, 5) == 0);
      cycle();
    end
    reset = 1'b0;
    idle();

    // Mid-expiry reset
    load(1);
    repeat (5) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check("rst_mid.timeout", int'(timeout1), 0);
    check("rst_mid.count",   int'(count4),   0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
